// File: rtl/frame_proc_fsm_p_if.sv
// Handshake and status bundle between the frame sequencer and its data source / word mux.
// The sequencer connects through master; the source side connects through slave.
interface frame_proc_fsm_p_if #(
    parameter int MAX_DATA = 1024
);
    localparam int CW = $clog2(MAX_DATA + 1);

    logic          EN;
    logic          VALID;
    logic          RD_EN;
    logic          TX_ACK;
    logic          CLR_CRC;
    logic          CRC_DV;
    logic [2:0]    SEL;
    logic [1:0]    CRC_IDX;
    logic          TRUNC;
    logic          FRM_DONE;
    logic [CW-1:0] FRM_LEN;
    logic [3:0]    FRM_STATE;

    modport master (
        input  EN, VALID,
        output RD_EN, TX_ACK, CLR_CRC, CRC_DV, SEL, CRC_IDX, TRUNC, FRM_DONE, FRM_LEN, FRM_STATE
    );

    modport slave (
        output EN, VALID,
        input  RD_EN, TX_ACK, CLR_CRC, CRC_DV, SEL, CRC_IDX, TRUNC, FRM_DONE, FRM_LEN, FRM_STATE
    );
endinterface

// File: rtl/frame_proc_fsm_p.sv
// Transmit frame sequencer: SOP, preamble, SOF, payload, pad, CRC, EOP, inter-frame gap.
// Every output is a flop loaded from the next-state decode, so outputs move with the state.
module frame_proc_fsm_p #(
    parameter int PRE_WORDS = 3,
    parameter int CRC_WORDS = 2,
    parameter int MIN_DATA  = 32,
    parameter int MAX_DATA  = 1024,
    parameter int IFG_CYC   = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    frame_proc_fsm_p_if.master    bus
);
    localparam int CW = $clog2(MAX_DATA + 1);
    localparam int IW = (IFG_CYC > 1) ? $clog2(IFG_CYC) : 1;

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        SOP  = 4'd1,
        PRE  = 4'd2,
        SOF  = 4'd3,
        DATA = 4'd4,
        PAD  = 4'd5,
        CRC  = 4'd6,
        EOP  = 4'd7,
        IFG  = 4'd8
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [CW-1:0] frm_len, frm_len_n;
    logic [3:0]    pre_cnt, pre_cnt_n;
    logic [1:0]    crc_idx, crc_idx_n;
    logic [IW-1:0] ifg_cnt, ifg_cnt_n;
    logic          rd_en, rd_en_n;
    logic          trunc, trunc_n;
    logic [2:0]    sel, sel_n;
    logic          clr_crc, clr_crc_n;
    logic          crc_dv, crc_dv_n;
    logic          tx_ack, tx_ack_n;
    logic          frm_done, frm_done_n;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        frm_len_n = frm_len;
        pre_cnt_n = pre_cnt;
        crc_idx_n = '0;
        ifg_cnt_n = ifg_cnt;
        rd_en_n   = 1'b0;
        trunc_n   = 1'b0;

        case (state)
            IDLE: begin
                if (bus.EN && bus.VALID) begin
                    state_n = SOP;
                    cnt_n   = '0;
                end
            end
            SOP: begin
                state_n   = PRE;
                pre_cnt_n = '0;
            end
            PRE: begin
                if (int'(pre_cnt) == PRE_WORDS - 1) state_n = SOF;
                else                                pre_cnt_n = pre_cnt + 1'b1;
            end
            SOF: begin
                state_n = DATA;
                if (bus.VALID) begin
                    rd_en_n = 1'b1;
                    cnt_n   = cnt + 1'b1;
                end
            end
            DATA: begin
                // A DATA cycle without a read is the terminating cycle, whatever VALID does now.
                if (rd_en && int'(cnt) == MAX_DATA) begin
                    state_n = CRC;
                    trunc_n = bus.VALID;
                end else if (rd_en && bus.VALID) begin
                    rd_en_n = 1'b1;
                    cnt_n   = cnt + 1'b1;
                end else if (int'(cnt) < MIN_DATA) begin
                    state_n = PAD;
                    cnt_n   = cnt + 1'b1;
                end else begin
                    state_n = CRC;
                end
            end
            PAD: begin
                if (int'(cnt) == MIN_DATA) state_n = CRC;
                else                       cnt_n   = cnt + 1'b1;
            end
            CRC: begin
                if (int'(crc_idx) == CRC_WORDS - 1) begin
                    state_n   = EOP;
                    frm_len_n = cnt;
                end else begin
                    crc_idx_n = crc_idx + 1'b1;
                end
            end
            EOP: begin
                if (IFG_CYC > 0) begin
                    state_n   = IFG;
                    ifg_cnt_n = '0;
                end else begin
                    state_n = IDLE;
                end
            end
            IFG: begin
                if (int'(ifg_cnt) == IFG_CYC - 1) state_n = IDLE;
                else                              ifg_cnt_n = ifg_cnt + 1'b1;
            end
            default: state_n = IDLE;
        endcase

        // Low three code bits equal the mux select for SOP..EOP; IDLE and IFG both map to 0.
        sel_n      = state_n[2:0];
        clr_crc_n  = (state_n == SOP) || (state_n == PRE) || (state_n == SOF);
        tx_ack_n   = (state_n == SOF);
        frm_done_n = (state_n == EOP);
        crc_dv_n   = rd_en_n || (state_n == PAD);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            cnt      <= '0;
            frm_len  <= '0;
            pre_cnt  <= '0;
            crc_idx  <= '0;
            ifg_cnt  <= '0;
            rd_en    <= 1'b0;
            trunc    <= 1'b0;
            sel      <= '0;
            clr_crc  <= 1'b0;
            crc_dv   <= 1'b0;
            tx_ack   <= 1'b0;
            frm_done <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            frm_len  <= frm_len_n;
            pre_cnt  <= pre_cnt_n;
            crc_idx  <= crc_idx_n;
            ifg_cnt  <= ifg_cnt_n;
            rd_en    <= rd_en_n;
            trunc    <= trunc_n;
            sel      <= sel_n;
            clr_crc  <= clr_crc_n;
            crc_dv   <= crc_dv_n;
            tx_ack   <= tx_ack_n;
            frm_done <= frm_done_n;
        end
    end

    assign bus.RD_EN     = rd_en;
    assign bus.TX_ACK    = tx_ack;
    assign bus.CLR_CRC   = clr_crc;
    assign bus.CRC_DV    = crc_dv;
    assign bus.SEL       = sel;
    assign bus.CRC_IDX   = crc_idx;
    assign bus.TRUNC     = trunc;
    assign bus.FRM_DONE  = frm_done;
    assign bus.FRM_LEN   = frm_len;
    assign bus.FRM_STATE = state;
endmodule

// File: tb/tb_frame_proc_fsm_p.sv
// Bench for frame_proc_fsm_p: two differently parameterised instances are driven from
// per-cycle stimulus tables, with expected outputs built frame-by-frame from the framing rules.
module tb_frame_proc_fsm_p;
    localparam int PRE_A = 3, CRC_A = 2, MIN_A = 32, MAX_A = 64, IFG_A = 4;
    localparam int PRE_B = 1, CRC_B = 4, MIN_B = 0,  MAX_B = 64, IFG_B = 0;

    typedef struct packed {
        logic [2:0] sel;
        logic [1:0] idx;
        logic       rd;
        logic       ack;
        logic       clr;
        logic       dv;
        logic       trunc;
        logic       done;
        logic [6:0] len;
        logic [3:0] st;
    } outv_t;

    typedef struct packed {
        logic rst;
        logic en;
        logic valid;
    } stim_t;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    always #5 clk = ~clk;

    frame_proc_fsm_p_if #(.MAX_DATA(MAX_A)) bus_a ();
    frame_proc_fsm_p_if #(.MAX_DATA(MAX_B)) bus_b ();

    frame_proc_fsm_p #(
        .PRE_WORDS(PRE_A), .CRC_WORDS(CRC_A), .MIN_DATA(MIN_A), .MAX_DATA(MAX_A), .IFG_CYC(IFG_A)
    ) dut_a (
        .CLK(clk), .RST(rst_a), .bus(bus_a.master)
    );

    frame_proc_fsm_p #(
        .PRE_WORDS(PRE_B), .CRC_WORDS(CRC_B), .MIN_DATA(MIN_B), .MAX_DATA(MAX_B), .IFG_CYC(IFG_B)
    ) dut_b (
        .CLK(clk), .RST(rst_b), .bus(bus_b.master)
    );

    int    compared   = 0;
    int    mismatched = 0;
    outv_t exp_a[$], exp_b[$];
    stim_t stim_a[$], stim_b[$];
    int    last_len[2];

    task automatic chk(input string name, input int act, input int req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic cmpv(input string name, input int cyc, input outv_t act, input outv_t req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s cycle %0d: got sel=%0d idx=%0d rd=%b ack=%b clr=%b dv=%b tr=%b done=%b len=%0d st=%0d, expected sel=%0d idx=%0d rd=%b ack=%b clr=%b dv=%b tr=%b done=%b len=%0d st=%0d",
                     name, cyc, act.sel, act.idx, act.rd, act.ack, act.clr, act.dv, act.trunc, act.done, act.len, act.st,
                     req.sel, req.idx, req.rd, req.ack, req.clr, req.dv, req.trunc, req.done, req.len, req.st);
        end
    endtask

    // Expected outputs for one cycle spent in the given frame phase.
    function automatic outv_t ev(input int inst, input int st, input int idx, input bit rd, input bit dv, input bit tr);
        outv_t v;
        v       = '0;
        v.st    = 4'(st);
        v.sel   = (st >= 1 && st <= 7) ? 3'(st) : 3'd0;
        v.idx   = 2'(idx);
        v.rd    = rd;
        v.dv    = dv;
        v.trunc = tr;
        v.ack   = (st == 3);
        v.clr   = (st >= 1 && st <= 3);
        v.done  = (st == 7);
        v.len   = 7'(last_len[inst]);
        return v;
    endfunction

    task automatic push(input int inst, input bit r, input bit e, input bit v, input outv_t x);
        stim_t s;
        s = '{rst: r, en: e, valid: v};
        if (inst == 0) begin stim_a.push_back(s); exp_a.push_back(x); end
        else           begin stim_b.push_back(s); exp_b.push_back(x); end
    endtask

    task automatic idle(input int inst, input int n);
        for (int i = 0; i < n; i++) push(inst, 1'b0, i[0], ~i[0], ev(inst, 0, 0, 0, 0, 0));
    endtask

    // Whole frame offering L words; VALID must be present one cycle ahead of each read.
    task automatic frame(input int inst, input int L);
        int p, c, mn, mx, ifg, n, pads;
        p   = (inst == 0) ? PRE_A : PRE_B;
        c   = (inst == 0) ? CRC_A : CRC_B;
        mn  = (inst == 0) ? MIN_A : MIN_B;
        mx  = (inst == 0) ? MAX_A : MAX_B;
        ifg = (inst == 0) ? IFG_A : IFG_B;
        n    = (L < mx) ? L : mx;
        pads = (mn > n) ? mn - n : 0;
        push(inst, 1'b0, 1'b1, 1'b1, ev(inst, 0, 0, 0, 0, 0));
        push(inst, 1'b0, 1'b1, 1'b1, ev(inst, 1, 0, 0, 0, 0));
        for (int k = 0; k < p; k++) push(inst, 1'b0, 1'b1, 1'b1, ev(inst, 2, 0, 0, 0, 0));
        push(inst, 1'b0, 1'b1, L > 0, ev(inst, 3, 0, 0, 0, 0));
        if (n == 0) push(inst, 1'b0, 1'b1, 1'b0, ev(inst, 4, 0, 0, 0, 0));
        for (int k = 1; k <= n; k++) push(inst, 1'b0, 1'b1, k < L, ev(inst, 4, 0, 1, 1, 0));
        for (int k = 0; k < pads; k++) push(inst, 1'b0, 1'b1, 1'b1, ev(inst, 5, 0, 0, 1, 0));
        for (int k = 0; k < c; k++) push(inst, 1'b0, 1'b1, 1'b1, ev(inst, 6, k, 0, 0, (k == 0) && (L > mx)));
        last_len[inst] = n + pads;
        push(inst, 1'b0, 1'b1, 1'b1, ev(inst, 7, 0, 0, 0, 0));
        for (int k = 0; k < ifg; k++) push(inst, 1'b0, 1'b1, 1'b1, ev(inst, 8, 0, 0, 0, 0));
    endtask

    // Frame cut by reset after k reads; outputs and FRM_LEN must read zero immediately.
    task automatic frame_abort(input int inst, input int k);
        int p;
        p = (inst == 0) ? PRE_A : PRE_B;
        push(inst, 1'b0, 1'b1, 1'b1, ev(inst, 0, 0, 0, 0, 0));
        push(inst, 1'b0, 1'b1, 1'b1, ev(inst, 1, 0, 0, 0, 0));
        for (int j = 0; j < p; j++) push(inst, 1'b0, 1'b1, 1'b1, ev(inst, 2, 0, 0, 0, 0));
        push(inst, 1'b0, 1'b1, 1'b1, ev(inst, 3, 0, 0, 0, 0));
        for (int j = 0; j < k; j++) push(inst, 1'b0, 1'b1, 1'b1, ev(inst, 4, 0, 1, 1, 0));
        last_len[inst] = 0;
        push(inst, 1'b1, 1'b0, 1'b0, ev(inst, 0, 0, 0, 0, 0));
        push(inst, 1'b0, 1'b0, 1'b0, ev(inst, 0, 0, 0, 0, 0));
    endtask

    function automatic int tally(input int inst, input int what);
        int    t;
        int    sz;
        outv_t x;
        t  = 0;
        sz = (inst == 0) ? exp_a.size() : exp_b.size();
        for (int i = 0; i < sz; i++) begin
            x = (inst == 0) ? exp_a[i] : exp_b[i];
            case (what)
                0:       t += int'(x.rd);
                1:       t += int'(x.dv && !x.rd);
                2:       t += int'(x.trunc);
                default: t += int'(x.done);
            endcase
        end
        return t;
    endfunction

    function automatic outv_t obs(input int inst);
        outv_t v;
        if (inst == 0)
            v = '{sel: bus_a.SEL, idx: bus_a.CRC_IDX, rd: bus_a.RD_EN, ack: bus_a.TX_ACK, clr: bus_a.CLR_CRC,
                  dv: bus_a.CRC_DV, trunc: bus_a.TRUNC, done: bus_a.FRM_DONE, len: bus_a.FRM_LEN, st: bus_a.FRM_STATE};
        else
            v = '{sel: bus_b.SEL, idx: bus_b.CRC_IDX, rd: bus_b.RD_EN, ack: bus_b.TX_ACK, clr: bus_b.CLR_CRC,
                  dv: bus_b.CRC_DV, trunc: bus_b.TRUNC, done: bus_b.FRM_DONE, len: bus_b.FRM_LEN, st: bus_b.FRM_STATE};
        return v;
    endfunction

    initial begin
        int    rd_obs[2], pad_obs[2], tr_obs[2], done_obs[2];
        int    eop_b, sop_b;
        outv_t oa, ob;

        rst_a = 1'b0; rst_b = 1'b0;
        bus_a.EN = 1'b0; bus_a.VALID = 1'b0;
        bus_b.EN = 1'b0; bus_b.VALID = 1'b0;
        last_len = '{0, 0};
        rd_obs = '{0, 0}; pad_obs = '{0, 0}; tr_obs = '{0, 0}; done_obs = '{0, 0};
        eop_b = -1; sop_b = -1;

        idle(0, 3);
        frame(0, 40);
        idle(0, 2);
        frame(0, 10);
        idle(0, 2);
        frame(0, 70);
        idle(0, 1);
        frame_abort(0, 5);
        idle(0, 3);
        frame(0, 33);
        idle(0, 2);

        idle(1, 2);
        frame(1, 3);
        frame(1, 5);
        frame(1, 0);
        idle(1, 2);
        frame(1, 64);
        idle(1, 2);

        while (exp_a.size() < exp_b.size()) push(0, 1'b0, 1'b0, 1'b0, ev(0, 0, 0, 0, 0, 0));
        while (exp_b.size() < exp_a.size()) push(1, 1'b0, 1'b0, 1'b0, ev(1, 0, 0, 0, 0, 0));

        chk("model_rd_a",    tally(0, 0), 152);
        chk("model_pad_a",   tally(0, 1), 22);
        chk("model_trunc_a", tally(0, 2), 1);
        chk("model_done_a",  tally(0, 3), 4);
        chk("model_rd_b",    tally(1, 0), 72);
        chk("model_trunc_b", tally(1, 2), 0);

        #1;
        rst_a = 1'b1; rst_b = 1'b1;
        @(negedge clk);
        chk("reset_state_a", int'(bus_a.FRM_STATE), 0);
        chk("reset_sel_a",   int'(bus_a.SEL), 0);
        chk("reset_len_a",   int'(bus_a.FRM_LEN), 0);
        chk("reset_clr_a",   int'(bus_a.CLR_CRC), 0);
        chk("reset_state_b", int'(bus_b.FRM_STATE), 0);

        for (int n = 0; n < exp_a.size(); n++) begin
            @(posedge clk);
            #1;
            rst_a = stim_a[n].rst; bus_a.EN = stim_a[n].en; bus_a.VALID = stim_a[n].valid;
            rst_b = stim_b[n].rst; bus_b.EN = stim_b[n].en; bus_b.VALID = stim_b[n].valid;
            @(negedge clk);
            oa = obs(0);
            ob = obs(1);
            cmpv("cycle_a", n, oa, exp_a[n]);
            cmpv("cycle_b", n, ob, exp_b[n]);
            rd_obs[0]   += int'(oa.rd);             rd_obs[1]   += int'(ob.rd);
            pad_obs[0]  += int'(oa.dv && !oa.rd);   pad_obs[1]  += int'(ob.dv && !ob.rd);
            tr_obs[0]   += int'(oa.trunc);          tr_obs[1]   += int'(ob.trunc);
            done_obs[0] += int'(oa.done);           done_obs[1] += int'(ob.done);
            if (eop_b < 0 && ob.st == 4'd7) eop_b = n;
            if (eop_b >= 0 && sop_b < 0 && ob.st == 4'd1) sop_b = n;
        end

        chk("dut_rd_a",    rd_obs[0], 152);
        chk("dut_pad_a",   pad_obs[0], 22);
        chk("dut_trunc_a", tr_obs[0], 1);
        chk("dut_done_a",  done_obs[0], 4);
        chk("dut_rd_b",    rd_obs[1], 72);
        chk("dut_pad_b",   pad_obs[1], 0);
        chk("dut_trunc_b", tr_obs[1], 0);
        chk("dut_done_b",  done_obs[1], 4);
        chk("b2b_eop_to_sop", sop_b - eop_b, 2);
        chk("final_len_a", int'(bus_a.FRM_LEN), 33);
        chk("final_len_b", int'(bus_b.FRM_LEN), 64);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
